// File: rtl/pipe_ctrl_pkg.sv
// Shared types for the pipeline hazard controller: FSM states, forward selects, x0 index.
package pipe_ctrl_pkg;
  typedef enum logic [1:0] {RUN, LU_STALL, MC_STALL} ctrl_state_e;
  typedef enum logic [1:0] {FWD_REG = 2'b00, FWD_WB = 2'b01, FWD_MEM = 2'b10} fwd_sel_e;
  localparam int REG_X0 = 0;
endpackage

// File: rtl/pipe_ctrl_fwd_select.sv
// Per-operand EX forward select; the younger MEM result wins over WB, x0 is never forwarded.
module fwd_select
  import pipe_ctrl_pkg::*;
#(
  parameter int REG_W = 5
) (
  input  logic [REG_W-1:0] rs,
  input  logic [REG_W-1:0] mem_rd,
  input  logic             mem_regwrite,
  input  logic [REG_W-1:0] wb_rd,
  input  logic             wb_regwrite,
  output fwd_sel_e         sel
);
  always_comb begin
    sel = FWD_REG;
    if (mem_regwrite && mem_rd != REG_W'(REG_X0) && mem_rd == rs)
      sel = FWD_MEM;
    else if (wb_regwrite && wb_rd != REG_W'(REG_X0) && wb_rd == rs)
      sel = FWD_WB;
  end
endmodule

// File: rtl/pipe_ctrl.sv
// In-order pipeline hazard controller: load-use and busy-EX interlocks, redirect flush,
// per-register valid tracking, operand forwarding and saturating perf counters.
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int NSTAGES       = 5,
  parameter int REG_W         = 5,
  parameter int RESOLVE_STAGE = 3,
  parameter int LOAD_LAT      = 1,
  parameter int CNT_W         = 32
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 if_valid,
  input  logic [REG_W-1:0]     id_rs1,
  input  logic [REG_W-1:0]     id_rs2,
  input  logic                 id_use_rs1,
  input  logic                 id_use_rs2,
  input  logic [REG_W-1:0]     ex_rs1,
  input  logic [REG_W-1:0]     ex_rs2,
  input  logic [REG_W-1:0]     ex_rd,
  input  logic                 ex_memread,
  input  logic                 ex_busy,
  input  logic [REG_W-1:0]     mem_rd,
  input  logic                 mem_regwrite,
  input  logic [REG_W-1:0]     wb_rd,
  input  logic                 wb_regwrite,
  input  logic                 redirect,
  output logic                 pc_en,
  output logic                 ifid_en,
  output logic [NSTAGES-2:0]   flush_vec,
  output logic [NSTAGES-2:0]   stage_valid,
  output logic [1:0]           fwd_a,
  output logic [1:0]           fwd_b,
  output logic [CNT_W-1:0]     stall_cycles,
  output logic [CNT_W-1:0]     flush_events
);
  localparam int NREG   = NSTAGES - 1;
  localparam int CNT_LW = (LOAD_LAT > 1) ? $clog2(LOAD_LAT) : 1;

  ctrl_state_e       state, state_nxt;
  logic [CNT_LW-1:0] cnt, cnt_nxt;
  logic              load_use, busy_hold;
  logic [NREG-1:0]   hold, sv_in;
  fwd_sel_e          sel_a, sel_b;

  assign load_use = ex_memread && ex_rd != REG_W'(REG_X0) &&
                    ((id_use_rs1 && id_rs1 == ex_rd) || (id_use_rs2 && id_rs2 == ex_rd));

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= RUN;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Outputs are gated by reset so an asserted reset shows run values even mid-stall.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    pc_en     = 1'b1;
    ifid_en   = 1'b1;
    flush_vec = '0;
    busy_hold = 1'b0;
    if (reset) begin
      if (redirect) begin
        for (int k = 0; k < NREG; k++)
          if (k < RESOLVE_STAGE) flush_vec[k] = 1'b1;
        state_nxt = RUN;
        cnt_nxt   = '0;
      end else if (ex_busy) begin
        pc_en        = 1'b0;
        ifid_en      = 1'b0;
        busy_hold    = 1'b1;
        flush_vec[2] = 1'b1;
        state_nxt    = MC_STALL;
        cnt_nxt      = '0;
      end else if (state == LU_STALL) begin
        pc_en        = 1'b0;
        ifid_en      = 1'b0;
        flush_vec[1] = 1'b1;
        cnt_nxt      = cnt - 1'b1;
        if (cnt == CNT_LW'(1)) state_nxt = RUN;
      end else if (load_use) begin
        pc_en        = 1'b0;
        ifid_en      = 1'b0;
        flush_vec[1] = 1'b1;
        if (LOAD_LAT == 1) begin
          state_nxt = RUN;
        end else begin
          state_nxt = LU_STALL;
          cnt_nxt   = CNT_LW'(LOAD_LAT - 1);
        end
      end else begin
        state_nxt = RUN;
      end
    end
  end

  // IF/ID holds whenever its enable drops; ID/EX holds only under a busy EX op.
  always_comb begin
    hold    = '0;
    hold[0] = ~ifid_en;
    hold[1] = busy_hold;
  end

  assign sv_in = {stage_valid[NREG-2:0], if_valid};

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      stage_valid <= '0;
    end else begin
      for (int k = 0; k < NREG; k++) begin
        if (flush_vec[k])  stage_valid[k] <= 1'b0;
        else if (!hold[k]) stage_valid[k] <= sv_in[k];
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      stall_cycles <= '0;
      flush_events <= '0;
    end else begin
      if (!pc_en && stall_cycles != '1) stall_cycles <= stall_cycles + 1'b1;
      if (redirect && flush_events != '1) flush_events <= flush_events + 1'b1;
    end
  end

  fwd_select #(.REG_W(REG_W)) u_fwd_a (
    .rs(ex_rs1), .mem_rd(mem_rd), .mem_regwrite(mem_regwrite),
    .wb_rd(wb_rd), .wb_regwrite(wb_regwrite), .sel(sel_a)
  );
  fwd_select #(.REG_W(REG_W)) u_fwd_b (
    .rs(ex_rs2), .mem_rd(mem_rd), .mem_regwrite(mem_regwrite),
    .wb_rd(wb_rd), .wb_regwrite(wb_regwrite), .sel(sel_b)
  );

  assign fwd_a = reset ? sel_a : FWD_REG;
  assign fwd_b = reset ? sel_b : FWD_REG;
endmodule

// File: tb/tb_pipe_ctrl.sv
// Bench for pipe_ctrl: u1 has LOAD_LAT=1 and wide counters, u3 has LOAD_LAT=3 and 2-bit counters.
module tb_pipe_ctrl;
  logic       clock, reset, if_valid, id_use_rs1, id_use_rs2, ex_memread, ex_busy;
  logic       mem_regwrite, wb_regwrite, redirect;
  logic [4:0] id_rs1, id_rs2, ex_rs1, ex_rs2, ex_rd, mem_rd, wb_rd;

  logic        pc_en1, ifid_en1, pc_en3, ifid_en3;
  logic [3:0]  flush1, sv1, flush3, sv3;
  logic [1:0]  fa1, fb1, fa3, fb3;
  logic [31:0] sc1, fe1;
  logic [1:0]  sc3, fe3;

  typedef struct {
    string       name;
    logic [31:0] val;
  } exp_t;
  exp_t sb[$];
  int   nchk = 0;
  int   npass = 0;

  // memread, ex_rd, use_rs1, rs1, use_rs2, rs2, expect_stall
  int lu_tbl [6][7] = '{
    '{1, 5, 1, 5, 0, 0, 1},
    '{1, 5, 0, 5, 0, 0, 0},
    '{1, 5, 0, 0, 1, 5, 1},
    '{1, 0, 1, 0, 0, 0, 0},
    '{0, 5, 1, 5, 0, 0, 0},
    '{1, 5, 1, 6, 1, 7, 0}
  };
  // mem_rd, mem_we, wb_rd, wb_we, ex_rs1, ex_rs2, fwd_a, fwd_b
  int fw_tbl [5][8] = '{
    '{7, 1, 7, 1, 7, 0, 2, 0},
    '{7, 0, 7, 1, 7, 7, 1, 1},
    '{0, 1, 0, 1, 0, 0, 0, 0},
    '{3, 1, 9, 1, 9, 3, 1, 2},
    '{4, 1, 4, 0, 6, 4, 0, 2}
  };

  pipe_ctrl #(.LOAD_LAT(1), .CNT_W(32)) u1 (
    .clock(clock), .reset(reset), .if_valid(if_valid),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
    .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd), .ex_memread(ex_memread), .ex_busy(ex_busy),
    .mem_rd(mem_rd), .mem_regwrite(mem_regwrite), .wb_rd(wb_rd), .wb_regwrite(wb_regwrite),
    .redirect(redirect), .pc_en(pc_en1), .ifid_en(ifid_en1), .flush_vec(flush1),
    .stage_valid(sv1), .fwd_a(fa1), .fwd_b(fb1), .stall_cycles(sc1), .flush_events(fe1)
  );
  pipe_ctrl #(.LOAD_LAT(3), .CNT_W(2)) u3 (
    .clock(clock), .reset(reset), .if_valid(if_valid),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
    .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd), .ex_memread(ex_memread), .ex_busy(ex_busy),
    .mem_rd(mem_rd), .mem_regwrite(mem_regwrite), .wb_rd(wb_rd), .wb_regwrite(wb_regwrite),
    .redirect(redirect), .pc_en(pc_en3), .ifid_en(ifid_en3), .flush_vec(flush3),
    .stage_valid(sv3), .fwd_a(fa3), .fwd_b(fb3), .stall_cycles(sc3), .flush_events(fe3)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, expected summary before 500us");
    $fatal(1, "watchdog");
  end

  task automatic idle();
    if_valid = 0; id_use_rs1 = 0; id_use_rs2 = 0; ex_memread = 0; ex_busy = 0;
    mem_regwrite = 0; wb_regwrite = 0; redirect = 0;
    id_rs1 = 0; id_rs2 = 0; ex_rs1 = 0; ex_rs2 = 0; ex_rd = 0; mem_rd = 0; wb_rd = 0;
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset = 0;
    idle();
    @(negedge clock);
    reset = 1;
  endtask

  task automatic fill_valid();
    if_valid = 1;
    repeat (4) @(negedge clock);
  endtask

  task automatic test_reset();
    exp_t e;
    @(negedge clock);
    #2 reset = 0;
    #1;
    sb.push_back('{"rst_pc_en", 32'd1});
    sb.push_back('{"rst_ifid_en", 32'd1});
    sb.push_back('{"rst_flush", 32'd0});
    sb.push_back('{"rst_valid", 32'd0});
    sb.push_back('{"rst_stall_cnt", 32'd0});
    sb.push_back('{"rst_flush_cnt", 32'd0});
    sb.push_back('{"rst_fwd", 32'd0});
    for (int i = 0; i < 7; i++) begin
      logic [31:0] act;
      e = sb.pop_front();
      case (i)
        0: act = 32'(pc_en1);
        1: act = 32'(ifid_en1);
        2: act = 32'(flush1);
        3: act = 32'(sv1);
        4: act = sc1;
        5: act = fe1;
        default: act = 32'({fa1, fb1});
      endcase
      nchk++;
      if (act !== e.val) $display("FAIL %s: got %0h expected %0h", e.name, act, e.val);
      else npass++;
    end
    @(negedge clock);
    reset = 1;
  endtask

  task automatic test_load_use_lat1();
    exp_t e;
    int   stalls = 0;
    do_reset();
    for (int r = 0; r < 6; r++) begin
      ex_memread = lu_tbl[r][0][0]; ex_rd = 5'(lu_tbl[r][1]);
      id_use_rs1 = lu_tbl[r][2][0]; id_rs1 = 5'(lu_tbl[r][3]);
      id_use_rs2 = lu_tbl[r][4][0]; id_rs2 = 5'(lu_tbl[r][5]);
      if (lu_tbl[r][6] != 0) stalls++;
      sb.push_back('{$sformatf("lu1_pc_en_r%0d", r), (lu_tbl[r][6] != 0) ? 32'd0 : 32'd1});
      sb.push_back('{$sformatf("lu1_flush_r%0d", r), (lu_tbl[r][6] != 0) ? 32'h2 : 32'h0});
      #1;
      e = sb.pop_front(); nchk++;
      if (32'(pc_en1) !== e.val) $display("FAIL %s: got %0h expected %0h", e.name, pc_en1, e.val);
      else npass++;
      e = sb.pop_front(); nchk++;
      if (32'(flush1) !== e.val) $display("FAIL %s: got %0h expected %0h", e.name, flush1, e.val);
      else npass++;
      sb.push_back('{$sformatf("lu1_stall_cnt_r%0d", r), 32'(stalls)});
      @(posedge clock); #1;
      e = sb.pop_front(); nchk++;
      if (sc1 !== e.val) $display("FAIL %s: got %0h expected %0h", e.name, sc1, e.val);
      else npass++;
      @(negedge clock);
      idle();
    end
  endtask

  task automatic test_load_use_lat3();
    exp_t e;
    do_reset();
    ex_memread = 1; ex_rd = 5; id_use_rs1 = 1; id_rs1 = 5;
    for (int c = 0; c < 4; c++) begin
      sb.push_back('{$sformatf("lu3_pc_en_c%0d", c), (c < 3) ? 32'd0 : 32'd1});
      sb.push_back('{$sformatf("lu3_flush_c%0d", c), (c < 3) ? 32'h2 : 32'h0});
      #1;
      e = sb.pop_front(); nchk++;
      if (32'(pc_en3) !== e.val) $display("FAIL %s: got %0h expected %0h", e.name, pc_en3, e.val);
      else npass++;
      e = sb.pop_front(); nchk++;
      if (32'(flush3) !== e.val) $display("FAIL %s: got %0h expected %0h", e.name, flush3, e.val);
      else npass++;
      @(negedge clock);
      ex_memread = 0;
    end
    sb.push_back('{"lu3_stall_cnt", 32'd3});
    e = sb.pop_front(); nchk++;
    if (32'(sc3) !== e.val) $display("FAIL %s: got %0h expected %0h", e.name, sc3, e.val);
    else npass++;
    idle();
  endtask

  task automatic test_ex_busy();
    exp_t e;
    logic [3:0] sv_exp [4] = '{4'b1011, 4'b0011, 4'b0011, 4'b0011};
    do_reset();
    fill_valid();
    for (int c = 0; c < 5; c++) begin
      ex_busy = (c < 4);
      sb.push_back('{$sformatf("busy_pc_en_c%0d", c), (c < 4) ? 32'd0 : 32'd1});
      sb.push_back('{$sformatf("busy_flush_c%0d", c), (c < 4) ? 32'h4 : 32'h0});
      #1;
      e = sb.pop_front(); nchk++;
      if (32'(pc_en1) !== e.val) $display("FAIL %s: got %0h expected %0h", e.name, pc_en1, e.val);
      else npass++;
      e = sb.pop_front(); nchk++;
      if (32'(flush1) !== e.val) $display("FAIL %s: got %0h expected %0h", e.name, flush1, e.val);
      else npass++;
      sb.push_back('{$sformatf("busy_valid_c%0d", c), (c < 4) ? 32'(sv_exp[c]) : 32'h7});
      @(posedge clock); #1;
      e = sb.pop_front(); nchk++;
      if (32'(sv1) !== e.val) $display("FAIL %s: got %0h expected %0h", e.name, sv1, e.val);
      else npass++;
      @(negedge clock);
    end
    sb.push_back('{"busy_stall_cnt", 32'd4});
    sb.push_back('{"busy_stall_cnt_sat", 32'd3});
    e = sb.pop_front(); nchk++;
    if (sc1 !== e.val) $display("FAIL %s: got %0h expected %0h", e.name, sc1, e.val);
    else npass++;
    e = sb.pop_front(); nchk++;
    if (32'(sc3) !== e.val) $display("FAIL %s: got %0h expected %0h", e.name, sc3, e.val);
    else npass++;
    idle();
  endtask

  task automatic test_redirect_in_stall();
    exp_t e;
    do_reset();
    fill_valid();
    ex_memread = 1; ex_rd = 5; id_use_rs1 = 1; id_rs1 = 5;
    @(negedge clock);
    ex_memread = 0; redirect = 1;
    sb.push_back('{"redir_flush", 32'h7});
    sb.push_back('{"redir_pc_en", 32'd1});
    sb.push_back('{"redir_ifid_en", 32'd1});
    #1;
    e = sb.pop_front(); nchk++;
    if (32'(flush3) !== e.val) $display("FAIL %s: got %0h expected %0h", e.name, flush3, e.val);
    else npass++;
    e = sb.pop_front(); nchk++;
    if (32'(pc_en3) !== e.val) $display("FAIL %s: got %0h expected %0h", e.name, pc_en3, e.val);
    else npass++;
    e = sb.pop_front(); nchk++;
    if (32'(ifid_en3) !== e.val) $display("FAIL %s: got %0h expected %0h", e.name, ifid_en3, e.val);
    else npass++;
    sb.push_back('{"redir_valid", 32'h8});
    sb.push_back('{"redir_flush_cnt", 32'd1});
    @(posedge clock); #1;
    e = sb.pop_front(); nchk++;
    if (32'(sv3) !== e.val) $display("FAIL %s: got %0h expected %0h", e.name, sv3, e.val);
    else npass++;
    e = sb.pop_front(); nchk++;
    if (32'(fe3) !== e.val) $display("FAIL %s: got %0h expected %0h", e.name, fe3, e.val);
    else npass++;
    @(negedge clock);
    idle();
    sb.push_back('{"redir_after_pc_en", 32'd1});
    sb.push_back('{"redir_after_stall_cnt", 32'd1});
    #1;
    e = sb.pop_front(); nchk++;
    if (32'(pc_en3) !== e.val) $display("FAIL %s: got %0h expected %0h", e.name, pc_en3, e.val);
    else npass++;
    e = sb.pop_front(); nchk++;
    if (32'(sc3) !== e.val) $display("FAIL %s: got %0h expected %0h", e.name, sc3, e.val);
    else npass++;
  endtask

  task automatic test_forwarding();
    exp_t e;
    do_reset();
    for (int r = 0; r < 5; r++) begin
      @(negedge clock);
      mem_rd = 5'(fw_tbl[r][0]); mem_regwrite = fw_tbl[r][1][0];
      wb_rd  = 5'(fw_tbl[r][2]); wb_regwrite  = fw_tbl[r][3][0];
      ex_rs1 = 5'(fw_tbl[r][4]); ex_rs2 = 5'(fw_tbl[r][5]);
      sb.push_back('{$sformatf("fwd_a_r%0d", r), 32'(fw_tbl[r][6])});
      sb.push_back('{$sformatf("fwd_b_r%0d", r), 32'(fw_tbl[r][7])});
      #1;
      e = sb.pop_front(); nchk++;
      if (32'(fa1) !== e.val) $display("FAIL %s: got %0h expected %0h", e.name, fa1, e.val);
      else npass++;
      e = sb.pop_front(); nchk++;
      if (32'(fb1) !== e.val) $display("FAIL %s: got %0h expected %0h", e.name, fb1, e.val);
      else npass++;
    end
    idle();
  endtask

  task automatic test_saturation_and_async_reset();
    exp_t e;
    do_reset();
    @(negedge clock);
    redirect = 1;
    repeat (5) @(negedge clock);
    redirect = 0;
    sb.push_back('{"sat_flush_cnt_wide", 32'd5});
    sb.push_back('{"sat_flush_cnt_narrow", 32'd3});
    e = sb.pop_front(); nchk++;
    if (fe1 !== e.val) $display("FAIL %s: got %0h expected %0h", e.name, fe1, e.val);
    else npass++;
    e = sb.pop_front(); nchk++;
    if (32'(fe3) !== e.val) $display("FAIL %s: got %0h expected %0h", e.name, fe3, e.val);
    else npass++;
    // Enter MC_STALL with forwarding active, then drop reset mid-cycle.
    ex_busy = 1; mem_rd = 7; mem_regwrite = 1; ex_rs1 = 7; if_valid = 1;
    @(posedge clock); #2;
    sb.push_back('{"mc_stall_cnt", 32'd1});
    e = sb.pop_front(); nchk++;
    if (sc1 !== e.val) $display("FAIL %s: got %0h expected %0h", e.name, sc1, e.val);
    else npass++;
    reset = 0;
    #1;
    sb.push_back('{"arst_pc_en", 32'd1});
    sb.push_back('{"arst_flush", 32'd0});
    sb.push_back('{"arst_valid", 32'd0});
    sb.push_back('{"arst_stall_cnt", 32'd0});
    sb.push_back('{"arst_fwd_a", 32'd0});
    e = sb.pop_front(); nchk++;
    if (32'(pc_en1) !== e.val) $display("FAIL %s: got %0h expected %0h", e.name, pc_en1, e.val);
    else npass++;
    e = sb.pop_front(); nchk++;
    if (32'(flush1) !== e.val) $display("FAIL %s: got %0h expected %0h", e.name, flush1, e.val);
    else npass++;
    e = sb.pop_front(); nchk++;
    if (32'(sv1) !== e.val) $display("FAIL %s: got %0h expected %0h", e.name, sv1, e.val);
    else npass++;
    e = sb.pop_front(); nchk++;
    if (sc1 !== e.val) $display("FAIL %s: got %0h expected %0h", e.name, sc1, e.val);
    else npass++;
    e = sb.pop_front(); nchk++;
    if (32'(fa1) !== e.val) $display("FAIL %s: got %0h expected %0h", e.name, fa1, e.val);
    else npass++;
    @(negedge clock);
    idle();
    reset = 1;
    #1;
    sb.push_back('{"post_rst_pc_en", 32'd1});
    sb.push_back('{"post_rst_flush", 32'd0});
    e = sb.pop_front(); nchk++;
    if (32'(pc_en1) !== e.val) $display("FAIL %s: got %0h expected %0h", e.name, pc_en1, e.val);
    else npass++;
    e = sb.pop_front(); nchk++;
    if (32'(flush1) !== e.val) $display("FAIL %s: got %0h expected %0h", e.name, flush1, e.val);
    else npass++;
  endtask

  initial begin
    reset = 0;
    idle();
    repeat (2) @(negedge clock);
    reset = 1;
    test_reset();
    test_load_use_lat1();
    test_load_use_lat3();
    test_ex_busy();
    test_redirect_in_stall();
    test_forwarding();
    test_saturation_and_async_reset();
    $display("%0d/%0d checks passed", npass, nchk);
    $finish;
  end
endmodule
